// File: rtl/uart_port_arbiter.sv
// Shares one UART TX/RX byte channel pair between two requesters (0: exec element, 1: loader/monitor).
// Each channel has its own IDLE/ACTIVE/RELEASE arbiter; requester 1 may lock both channels.

module uart_arb_channel #(
  parameter int FIXED_PRIORITY = 0,
  parameter int LATCH_AT_GRANT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic [7:0] grant_data0,
  input  logic [7:0] grant_data1,
  input  logic       down_ready,
  input  logic [7:0] cap_data,
  output logic       down_valid,
  output logic [1:0] ready,
  output logic [7:0] data,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RELEASE} state_t;

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [1:0] elig;
  logic       pick;

  always_comb begin
    elig = lock ? (req & 2'b10) : req;
    pick = (elig == 2'b11) ? ((FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant) : elig[1];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      down_valid <= 1'b0;
      ready      <= 2'b00;
      data       <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 2'b00;
          if (elig != 2'b00) begin
            owner      <= pick;
            down_valid <= 1'b1;
            state      <= S_ACTIVE;
            if (LATCH_AT_GRANT != 0) data <= pick ? grant_data1 : grant_data0;
          end
        end
        S_ACTIVE: begin
          if (down_ready) begin
            down_valid <= 1'b0;
            ready      <= owner ? 2'b10 : 2'b01;
            last_grant <= owner;
            state      <= S_RELEASE;
            if (LATCH_AT_GRANT == 0) data <= cap_data;
          end
        end
        S_RELEASE: begin
          // The owner drops its valid while we sit here, so it cannot be re-granted stale.
          ready <= 2'b00;
          state <= S_IDLE;
        end
        default: begin
          ready      <= 2'b00;
          down_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

module uart_port_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tx_valid,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_ready,
  input  logic [1:0] rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_ready,
  input  logic       lock,
  output logic       uart_in_valid,
  output logic [7:0] uart_in_data,
  input  logic       uart_in_ready,
  output logic       uart_out_valid,
  input  logic [7:0] uart_out_data,
  input  logic       uart_out_ready,
  output logic       tx_busy,
  output logic       rx_busy
);

  uart_arb_channel #(.FIXED_PRIORITY(FIXED_PRIORITY), .LATCH_AT_GRANT(1)) u_tx (
    .clk(clk), .reset(reset), .req(tx_valid), .lock(lock),
    .grant_data0(tx_data0), .grant_data1(tx_data1),
    .down_ready(uart_in_ready), .cap_data(8'h00),
    .down_valid(uart_in_valid), .ready(tx_ready), .data(uart_in_data), .busy(tx_busy)
  );

  // RX latches nothing at grant; the byte is captured when the UART delivers it.
  uart_arb_channel #(.FIXED_PRIORITY(FIXED_PRIORITY), .LATCH_AT_GRANT(0)) u_rx (
    .clk(clk), .reset(reset), .req(rx_valid), .lock(lock),
    .grant_data0(8'h00), .grant_data1(8'h00),
    .down_ready(uart_out_ready), .cap_data(uart_out_data),
    .down_valid(uart_out_valid), .ready(rx_ready), .data(rx_data), .busy(rx_busy)
  );

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_uart_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data1 = 8'h00;
  logic [1:0] rx_valid = 2'b00;
  logic       lock = 1'b0;
  logic       uart_in_ready = 1'b0;
  logic [7:0] uart_out_data = 8'h00;
  logic       uart_out_ready = 1'b0;

  logic [1:0] tx_ready, rx_ready;
  logic [7:0] rx_data, uart_in_data;
  logic       uart_in_valid, uart_out_valid, tx_busy, rx_busy;

  logic [1:0] fp_tx_ready, fp_rx_ready;
  logic [7:0] fp_rx_data, fp_uart_in_data;
  logic       fp_uart_in_valid, fp_uart_out_valid, fp_tx_busy, fp_rx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_port_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .lock(lock),
    .uart_in_valid(uart_in_valid), .uart_in_data(uart_in_data), .uart_in_ready(uart_in_ready),
    .uart_out_valid(uart_out_valid), .uart_out_data(uart_out_data), .uart_out_ready(uart_out_ready),
    .tx_busy(tx_busy), .rx_busy(rx_busy)
  );

  uart_port_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .tx_ready(fp_tx_ready), .rx_valid(rx_valid), .rx_data(fp_rx_data), .rx_ready(fp_rx_ready), .lock(lock),
    .uart_in_valid(fp_uart_in_valid), .uart_in_data(fp_uart_in_data), .uart_in_ready(uart_in_ready),
    .uart_out_valid(fp_uart_out_valid), .uart_out_data(uart_out_data), .uart_out_ready(uart_out_ready),
    .tx_busy(fp_tx_busy), .rx_busy(fp_rx_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    tx_valid = 2'b00; rx_valid = 2'b00; lock = 1'b0;
    uart_in_ready = 1'b0; uart_out_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    tx_valid = 2'b00; rx_valid = 2'b00; lock = 1'b0;
    uart_in_ready = 1'b0; uart_out_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_valid = 2'b11; rx_valid = 2'b11; uart_in_ready = 1'b1; uart_out_ready = 1'b1;
    tick();
    tick();
    checks++; if ({uart_in_valid, uart_out_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b exp 00", {uart_in_valid, uart_out_valid}); end
    checks++; if ({tx_ready, rx_ready} !== 4'b0000) begin errors++; $display("FAIL reset_readys: got %b exp 0000", {tx_ready, rx_ready}); end
    checks++; if ({uart_in_data, rx_data} !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h exp 0000", {uart_in_data, rx_data}); end
    checks++; if ({tx_busy, rx_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b exp 00", {tx_busy, rx_busy}); end
    tx_valid = 2'b00; rx_valid = 2'b00; uart_in_ready = 1'b0; uart_out_ready = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_tx();
    tx_valid = 2'b01; tx_data0 = 8'h41; tx_data1 = 8'hEE;
    tick();
    checks++; if (uart_in_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", uart_in_valid); end
    checks++; if (uart_in_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h exp 41", uart_in_data); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", tx_busy); end
    tick();
    tick();
    checks++; if ({uart_in_valid, tx_ready} !== 3'b100) begin errors++; $display("FAIL single_hold: got %b exp 100", {uart_in_valid, tx_ready}); end
    uart_in_ready = 1'b1;
    tick();
    checks++; if (tx_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", tx_ready); end
    checks++; if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b exp 0", uart_in_valid); end
    tx_valid = 2'b00; uart_in_ready = 1'b0;
    tick();
    checks++; if (tx_ready !== 2'b00) begin errors++; $display("FAIL single_pulse_len: got %b exp 00", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", tx_busy); end
    quiesce();
  endtask

  task automatic test_round_robin();
    logic [7:0] rr_q[$];
    logic [7:0] fp_q[$];
    logic [7:0] rr_exp [4];
    logic       prev_rr, prev_fp;
    rr_exp[0] = 8'h10; rr_exp[1] = 8'h20; rr_exp[2] = 8'h10; rr_exp[3] = 8'h20;
    do_reset();
    prev_rr = 1'b0; prev_fp = 1'b0;
    tx_valid = 2'b11; tx_data0 = 8'h10; tx_data1 = 8'h20; uart_in_ready = 1'b1;
    repeat (16) begin
      tick();
      if (uart_in_valid && !prev_rr) rr_q.push_back(uart_in_data);
      if (fp_uart_in_valid && !prev_fp) fp_q.push_back(fp_uart_in_data);
      prev_rr = uart_in_valid; prev_fp = fp_uart_in_valid;
    end
    checks++; if (rr_q.size() < 4) begin errors++; $display("FAIL rr_count: got %0d exp >=4", rr_q.size()); end
    checks++; if (fp_q.size() < 4) begin errors++; $display("FAIL fp_count: got %0d exp >=4", fp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rr_q.size()) begin
        checks++; if (rr_q[i] !== rr_exp[i]) begin errors++; $display("FAIL rr_order[%0d]: got %h exp %h", i, rr_q[i], rr_exp[i]); end
      end
      if (i < fp_q.size()) begin
        checks++; if (fp_q[i] !== 8'h10) begin errors++; $display("FAIL fp_order[%0d]: got %h exp 10", i, fp_q[i]); end
      end
    end
    quiesce();
  endtask

  task automatic test_rx();
    rx_valid = 2'b10; uart_out_data = 8'h5A;
    tick();
    checks++; if ({uart_out_valid, rx_ready} !== 3'b100) begin errors++; $display("FAIL rx_grant: got %b exp 100", {uart_out_valid, rx_ready}); end
    uart_out_ready = 1'b1;
    tick();
    checks++; if (rx_ready !== 2'b10) begin errors++; $display("FAIL rx_ready: got %b exp 10", rx_ready); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rx_data: got %h exp 5a", rx_data); end
    rx_valid = 2'b00; uart_out_ready = 1'b0; uart_out_data = 8'h00;
    tick();
    checks++; if ({rx_ready, rx_data} !== {2'b00, 8'h5A}) begin errors++; $display("FAIL rx_hold: got %b/%h exp 00/5a", rx_ready, rx_data); end
    tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rx_idle: got %b exp 0", rx_busy); end
    quiesce();
  endtask

  task automatic test_lock();
    do_reset();
    lock = 1'b1; tx_valid = 2'b11; tx_data0 = 8'h10; tx_data1 = 8'h20;
    tick();
    checks++; if ({uart_in_valid, uart_in_data} !== {1'b1, 8'h20}) begin errors++; $display("FAIL lock_grant: got %b/%h exp 1/20", uart_in_valid, uart_in_data); end
    tick();
    lock = 1'b0;
    tick();
    uart_in_ready = 1'b1;
    tick();
    checks++; if (tx_ready !== 2'b10) begin errors++; $display("FAIL lock_ready: got %b exp 10", tx_ready); end
    tx_valid = 2'b01; uart_in_ready = 1'b0;
    tick();
    tick();
    checks++; if ({uart_in_valid, uart_in_data} !== {1'b1, 8'h10}) begin errors++; $display("FAIL lock_after: got %b/%h exp 1/10", uart_in_valid, uart_in_data); end
    uart_in_ready = 1'b1;
    tick();
    checks++; if (tx_ready !== 2'b01) begin errors++; $display("FAIL lock_r0_ready: got %b exp 01", tx_ready); end
    quiesce();
  endtask

  task automatic test_concurrency();
    tx_valid = 2'b01; tx_data0 = 8'h33; rx_valid = 2'b10; uart_out_data = 8'h77;
    tick();
    checks++; if ({uart_in_valid, uart_out_valid, uart_in_data} !== {2'b11, 8'h33}) begin errors++; $display("FAIL conc_grant: got %b%b/%h exp 11/33", uart_in_valid, uart_out_valid, uart_in_data); end
    uart_out_ready = 1'b1;
    tick();
    checks++; if ({rx_ready, tx_ready, uart_in_valid} !== 5'b10001) begin errors++; $display("FAIL conc_rx_done: got %b exp 10001", {rx_ready, tx_ready, uart_in_valid}); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL conc_rx_data: got %h exp 77", rx_data); end
    rx_valid = 2'b00; uart_out_ready = 1'b0; uart_in_ready = 1'b1;
    tick();
    checks++; if ({tx_ready, rx_ready} !== 4'b0100) begin errors++; $display("FAIL conc_tx_done: got %b exp 0100", {tx_ready, rx_ready}); end
    tx_valid = 2'b00; uart_in_ready = 1'b0;
    tick();
    tick();
    checks++; if ({tx_busy, rx_busy} !== 2'b00) begin errors++; $display("FAIL conc_idle: got %b exp 00", {tx_busy, rx_busy}); end
    quiesce();
  endtask

  task automatic test_reset_mid();
    tx_valid = 2'b01; tx_data0 = 8'h55; rx_valid = 2'b10;
    tick();
    #1 reset = 1'b0;
    #1;
    checks++; if ({uart_in_valid, tx_ready, rx_ready, uart_out_valid} !== 6'b0) begin errors++; $display("FAIL midrst_clear: got %b exp 000000", {uart_in_valid, tx_ready, rx_ready, uart_out_valid}); end
    tx_valid = 2'b11; tx_data0 = 8'h10; tx_data1 = 8'h20; rx_valid = 2'b00;
    uart_in_ready = 1'b1;
    tick();
    checks++; if (tx_ready !== 2'b00) begin errors++; $display("FAIL midrst_no_pulse: got %b exp 00", tx_ready); end
    uart_in_ready = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if ({uart_in_valid, uart_in_data} !== {1'b1, 8'h10}) begin errors++; $display("FAIL midrst_regrant: got %b/%h exp 1/10", uart_in_valid, uart_in_data); end
    uart_in_ready = 1'b1;
    tick();
    checks++; if (tx_ready !== 2'b01) begin errors++; $display("FAIL midrst_ready: got %b exp 01", tx_ready); end
    quiesce();
  endtask

  // Transaction model: a free channel grants the eligible requester at the edge it samples it,
  // completes on the UART handshake, then rests one edge before it may grant again.
  task automatic test_random(input int cycles);
    int         phase [2];
    int         own [2];
    int         last [2];
    logic [7:0] exp_tx, exp_rx;
    logic [1:0] exp_pulse [2];
    logic [1:0] p_req [2];
    logic [1:0] p_rdy;
    logic       p_lock;
    logic [7:0] p_d0, p_d1, p_od;
    logic [1:0] elig;
    do_reset();
    for (int c = 0; c < 2; c++) begin phase[c] = 0; own[c] = 0; last[c] = 1; end
    exp_tx = 8'h00; exp_rx = 8'h00;
    for (int n = 0; n < cycles; n++) begin
      p_req[0] = tx_valid; p_req[1] = rx_valid; p_lock = lock;
      p_rdy = {uart_out_ready, uart_in_ready};
      p_d0 = tx_data0; p_d1 = tx_data1; p_od = uart_out_data;
      tick();
      for (int c = 0; c < 2; c++) begin
        exp_pulse[c] = 2'b00;
        if (phase[c] == 0) begin
          elig = p_lock ? (p_req[c] & 2'b10) : p_req[c];
          if (elig != 2'b00) begin
            if (elig == 2'b11) own[c] = 1 - last[c];
            else own[c] = elig[1] ? 1 : 0;
            phase[c] = 1;
            if (c == 0) exp_tx = (own[c] == 1) ? p_d1 : p_d0;
          end
        end else if (phase[c] == 1) begin
          if (p_rdy[c]) begin
            exp_pulse[c] = (own[c] == 1) ? 2'b10 : 2'b01;
            last[c] = own[c];
            phase[c] = 2;
            if (c == 1) exp_rx = p_od;
          end
        end else begin
          phase[c] = 0;
        end
      end
      checks++; if (uart_in_valid !== (phase[0] == 1)) begin errors++; $display("FAIL rnd_tx_valid @%0d: got %b exp %b", n, uart_in_valid, phase[0] == 1); end
      checks++; if (tx_ready !== exp_pulse[0]) begin errors++; $display("FAIL rnd_tx_ready @%0d: got %b exp %b", n, tx_ready, exp_pulse[0]); end
      checks++; if (tx_busy !== (phase[0] != 0)) begin errors++; $display("FAIL rnd_tx_busy @%0d: got %b exp %b", n, tx_busy, phase[0] != 0); end
      if (phase[0] == 1) begin
        checks++; if (uart_in_data !== exp_tx) begin errors++; $display("FAIL rnd_tx_data @%0d: got %h exp %h", n, uart_in_data, exp_tx); end
      end
      checks++; if (uart_out_valid !== (phase[1] == 1)) begin errors++; $display("FAIL rnd_rx_valid @%0d: got %b exp %b", n, uart_out_valid, phase[1] == 1); end
      checks++; if (rx_ready !== exp_pulse[1]) begin errors++; $display("FAIL rnd_rx_ready @%0d: got %b exp %b", n, rx_ready, exp_pulse[1]); end
      checks++; if (rx_busy !== (phase[1] != 0)) begin errors++; $display("FAIL rnd_rx_busy @%0d: got %b exp %b", n, rx_busy, phase[1] != 0); end
      checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL rnd_rx_data @%0d: got %h exp %h", n, rx_data, exp_rx); end
      // Requesters hold valid until their own pulse, then drop it for at least that edge.
      for (int i = 0; i < 2; i++) begin
        if (tx_ready[i]) tx_valid[i] = 1'b0;
        else if (!tx_valid[i] && $urandom_range(3) == 0) begin
          tx_valid[i] = 1'b1;
          if (i == 0) tx_data0 = 8'($urandom); else tx_data1 = 8'($urandom);
        end
        if (rx_ready[i]) rx_valid[i] = 1'b0;
        else if (!rx_valid[i] && $urandom_range(3) == 0) rx_valid[i] = 1'b1;
      end
      uart_in_ready = ($urandom_range(2) == 0);
      uart_out_ready = ($urandom_range(2) == 0);
      uart_out_data = 8'($urandom);
      if ($urandom_range(19) == 0) lock = ~lock;
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_round_robin();
    test_rx();
    test_lock();
    test_concurrency();
    test_reset_mid();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
